demux4_64_q: RTL and testbench
==============================

Name: demux4_64_q

Overview:
- 64-bit 1-to-4 distributor: the write-side counterpart of the 4:1 64-bit route mux.
- One producer presents a word plus a 2-bit destination select. The word is steered into one of four per-destination queues. Each queue drains independently to its consumer through valid/ready.
- Used where one result stream fans out to four sinks (e.g. writeback/forwarding consumers) that can each stall.

Parameters:
- WIDTH, 64, data width per word.
- DEPTH, 2, entries per destination queue. Power of 2, >= 2.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low. reset==0 at posedge clears all state.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_sel  input  2  destination: 3=outThree, 2=outTwo, 1=outOne, 0=outZero.
- in_data  input  WIDTH  word to route.
- outThree, outTwo, outOne, outZero  output  WIDTH each  head-of-queue data per destination.
- out_valid  output  4  bit i = queue i non-empty (bit 3 = outThree).
- out_ready  input  4  bit i = consumer i takes the head word.
- occupancy  output  4*($clog2(DEPTH)+1)  per-queue entry count, queue i in slice i.

Behaviour:
- Reset:
  - All queues empty; count=0; read/write pointers=0.
  - out_valid=4'b0000; occupancy=0.
  - outThree..outZero=0 (storage cleared).
  - in_ready is combinational and reads 1 after reset.
  - Reset mid-operation discards all queued words. No partial pops.
- Accept:
  - push = in_valid & in_ready.
  - in_ready = (count[in_sel] < DEPTH) | (out_valid[in_sel] & out_ready[in_sel]).
  - in_ready depends only on the queue selected by in_sel. The other queues' state does not affect it, so there is no head-of-line blocking between destinations.
  - in_ready may depend combinationally on in_sel and out_ready.
- Pop: pop[i] = out_valid[i] & out_ready[i]. Asserting out_ready[i] while the queue is empty has no effect.
- Latency:
  - A word pushed at cycle N appears on out[i] with out_valid[i]=1 at cycle N+1 if the queue was empty. There is no combinational in-to-out path.
  - Words to the same destination leave in arrival order.
  - Words to different destinations have no relative ordering guarantee.
- Queue i update per cycle:
  - count += push_i - pop[i].
  - Push and pop on the same cycle when full is legal: count stays DEPTH and the word is stored.
  - Push and pop on the same cycle when count==1: head advances to the new word.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH naturally.
- Output data: out[i] = storage[i][rd_ptr[i]]. The value is don't-care while out_valid[i]=0, except immediately after reset, when it is 0.
- Ignored input: in_valid=0 means in_sel and in_data are ignored, even if X.
- Holding rule: while out_valid[i]=1 and out_ready[i]=0, out[i] and out_valid[i] stay stable.

Decomposition:
- Shared package demux_pkg:
  - localparams SEL_ZERO=2'd0, SEL_ONE=2'd1, SEL_TWO=2'd2, SEL_THREE=2'd3.
  - typedef for the 2-bit select.
- Sub-module dest_queue (WIDTH, DEPTH):
  - Single-destination synchronous FIFO.
  - Ports: clk, reset, push, push_data, pop, head_data, not_empty, can_push, count. can_push includes the same-cycle-pop term.
  - Instantiated 4x in a generate loop.
- Top level: select decode, in_ready mux, and port flattening.

Test Plan:
- Basic routing:
  - Stimulus: after reset, with out_ready=4'b1111, push 64'hA3 sel=3, 64'hA2 sel=2, 64'hA1 sel=1, 64'hA0 sel=0 on consecutive cycles.
  - Required: each value appears one cycle later on outThree, outTwo, outOne, outZero respectively, each with its out_valid bit pulsing 1 cycle.
- Fill and backpressure:
  - Stimulus: out_ready=0; push 64'h1, 64'h2 to sel=1, then present 64'h3 sel=1.
  - Required: after the second push occupancy[1]=2 and in_ready=0 for 64'h3. With in_sel=2, in_ready=1 in the same state.
- Full with simultaneous push/pop:
  - Stimulus: from the full sel=1 state, raise out_ready[1] while presenting 64'h3.
  - Required: in_ready=1 and the push is accepted. outOne shows 1, 2, 3 in order; occupancy[1] stays 2, then drains to 0.
- Stall stability:
  - Stimulus: word 64'hDEAD_BEEF to sel=0; hold out_ready[0]=0 for 5 cycles.
  - Required: outZero and out_valid[0] are constant over those cycles; releasing out_ready[0] pops it exactly once.
- Wrap-around:
  - Stimulus: 10 words 64'h10..64'h19 to sel=2, with out_ready[2] toggling every cycle.
  - Required: outputs arrive in order, with no duplicates or drops.
- Reset mid-operation:
  - Stimulus: queues 0 and 3 hold 2 words each; drive reset=0 for one clock.
  - Required: out_valid=0, occupancy all 0, in_ready=1. The next push to sel=3 is the only word seen on outThree.

Source files
------------

// File: rtl/demux4_64_q_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : demux_pkg
//  Description : Shared definitions for the 1-to-4 queued distributor:
//                destination select type, select encodings and a one-hot
//                decode helper.
//  Contents    : sel_t        - 2-bit destination select
//                SEL_*        - select encodings (0=outZero .. 3=outThree)
//                sel_onehot() - 2-bit select to 4-bit one-hot
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_ZERO  = 2'd0;
   localparam sel_t SEL_ONE   = 2'd1;
   localparam sel_t SEL_TWO   = 2'd2;
   localparam sel_t SEL_THREE = 2'd3;

   localparam int NUM_DEST = 4;

   // Bit i of the result is set when s selects destination i.
   function automatic logic [NUM_DEST-1:0] sel_onehot(input sel_t s);
      logic [NUM_DEST-1:0] oh;
      oh = '0;
      oh[s] = 1'b1;
      return oh;
   endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux4_64_q_dest_queue.sv
`default_nettype none
// ============================================================================
//  Module      : dest_queue
//  Description : Single-destination synchronous FIFO. Storage is cleared by
//                reset so the head word reads 0 until the first push.
//  Ports       : clk        - clock, all state updates on posedge
//                reset      - synchronous, active-low clear of all state
//                push       - write push_data (ignored unless can_push)
//                push_data  - word to enqueue
//                pop        - consumer takes head (ignored while empty)
//                head_data  - word at the read pointer
//                not_empty  - queue holds at least one word
//                can_push   - a push this cycle would be accepted
//                count      - number of stored words, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module dest_queue #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     not_empty,
   output logic                     can_push,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] cnt;

   logic pop_eff;
   logic push_eff;

   assign not_empty = (cnt != '0);
   assign pop_eff   = pop & not_empty;
   // A full queue still accepts when the head leaves in the same cycle:
   // the freed slot is exactly the one the write pointer now addresses.
   assign can_push  = (cnt < CNT_W'(DEPTH)) | pop_eff;
   assign push_eff  = push & can_push;

   assign head_data = mem[rd_ptr];
   assign count     = cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            mem[k] <= '0;
         end
      end else begin
         if (push_eff) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_eff) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_eff, pop_eff})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule : dest_queue
`default_nettype wire

// File: rtl/demux4_64_q.sv
`default_nettype none
// ============================================================================
//  Module      : demux4_64_q
//  Description : 64-bit 1-to-4 distributor. A producer word is steered by
//                in_sel into one of four independent queues; each queue
//                drains to its own consumer through valid/ready.
//  Ports       : clk        - clock
//                reset      - synchronous, active-low
//                in_valid   - producer has a word
//                in_ready   - word accepted this cycle (selected queue only)
//                in_sel     - destination 0..3
//                in_data    - word to route
//                outZero..outThree - head word of each queue
//                out_valid  - bit i: queue i non-empty
//                out_ready  - bit i: consumer i takes the head word
//                occupancy  - per-queue entry count, queue i in slice i
//  Revision    : 1.0 - initial release
// ============================================================================
module demux4_64_q
   import demux_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [1:0]                        in_sel,
   input  logic [WIDTH-1:0]                  in_data,
   output logic [WIDTH-1:0]                  outThree,
   output logic [WIDTH-1:0]                  outTwo,
   output logic [WIDTH-1:0]                  outOne,
   output logic [WIDTH-1:0]                  outZero,
   output logic [3:0]                        out_valid,
   input  logic [3:0]                        out_ready,
   output logic [4*($clog2(DEPTH)+1)-1:0]    occupancy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0]    head     [NUM_DEST];
   logic [NUM_DEST-1:0] can_push;
   logic [NUM_DEST-1:0] push_vec;
   logic [NUM_DEST-1:0] sel_dec;

   // Readiness looks only at the addressed queue, so a stalled consumer
   // never blocks traffic headed for the other three.
   assign in_ready = can_push[in_sel];
   assign sel_dec  = sel_onehot(sel_t'(in_sel));
   assign push_vec = {NUM_DEST{in_valid & in_ready}} & sel_dec;

   for (genvar i = 0; i < NUM_DEST; i++) begin : g_queue
      logic [CNT_W-1:0] cnt;

      dest_queue #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_queue (
         .clk       (clk),
         .reset     (reset),
         .push      (push_vec[i]),
         .push_data (in_data),
         .pop       (out_ready[i]),
         .head_data (head[i]),
         .not_empty (out_valid[i]),
         .can_push  (can_push[i]),
         .count     (cnt)
      );

      assign occupancy[i*CNT_W +: CNT_W] = cnt;
   end

   assign outZero  = head[SEL_ZERO];
   assign outOne   = head[SEL_ONE];
   assign outTwo   = head[SEL_TWO];
   assign outThree = head[SEL_THREE];

endmodule : demux4_64_q
`default_nettype wire

// File: tb/tb_demux4_64_q.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux4_64_q
//  Description : Scoreboard bench for demux4_64_q. Stimulus appends accepted
//                words to per-destination expectation queues; a negedge
//                monitor compares every DUT output against them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux4_64_q;

   localparam int WIDTH = 64;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_sel;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] outThree, outTwo, outOne, outZero;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [4*CW-1:0]  occupancy;

   demux4_64_q #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .outThree  (outThree),
      .outTwo    (outTwo),
      .outOne    (outOne),
      .outZero   (outZero),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Words accepted but not yet taken by the consumer, per destination.
   logic [WIDTH-1:0] exp_q [4][$];
   int               pops  [4];
   bit               mon_en = 1'b0;
   bit               hold      [4];
   logic [WIDTH-1:0] hold_data [4];

   logic [WIDTH-1:0] outs [4];
   assign outs[0] = outZero;
   assign outs[1] = outOne;
   assign outs[2] = outTwo;
   assign outs[3] = outThree;

   task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
      end
   endtask

   // Monitor: outputs reflect the state before the next posedge.
   always @(negedge clk) begin
      if (!mon_en) begin
         for (int i = 0; i < 4; i++) hold[i] = 1'b0;
      end else begin
         int  sz;
         bit  exp_rdy;
         for (int i = 0; i < 4; i++) begin
            sz = exp_q[i].size();
            chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(sz > 0));
            chk($sformatf("occupancy[%0d]", i), 64'(occupancy[i*CW +: CW]), 64'(sz));
            if (sz > 0) chk($sformatf("data[%0d]", i), outs[i], exp_q[i][0]);
            if (hold[i]) begin
               chk($sformatf("hold_data[%0d]", i), outs[i], hold_data[i]);
               chk($sformatf("hold_valid[%0d]", i), 64'(out_valid[i]), 64'd1);
            end
         end
         sz      = exp_q[in_sel].size();
         exp_rdy = (sz < DEPTH) || (sz > 0 && out_ready[in_sel]);
         chk("in_ready", 64'(in_ready), 64'(exp_rdy));
         for (int i = 0; i < 4; i++) begin
            sz           = exp_q[i].size();
            hold[i]      = (sz > 0) && !out_ready[i];
            hold_data[i] = outs[i];
            if (sz > 0 && out_ready[i]) begin
               void'(exp_q[i].pop_front());
               pops[i]++;
            end
         end
      end
   end

   // One clock of stimulus; returns whether the model expects acceptance.
   task automatic step(input bit v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                       input logic [3:0] r, output bit acc);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      @(negedge clk);
      #2;
      // Monitor has already applied this cycle's pops.
      acc = v && (exp_q[s].size() < DEPTH);
      if (acc) exp_q[s].push_back(d);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [3:0] r, input int n);
      bit a;
      for (int k = 0; k < n; k++) step(1'b0, 2'd0, '0, r, a);
   endtask

   task automatic do_reset();
      mon_en    = 1'b0;
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      for (int i = 0; i < 4; i++) exp_q[i].delete();
      @(posedge clk);
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 4; i++) chk($sformatf("rst_data[%0d]", i), outs[i], 64'd0);
      #(-1 + 1);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit a;
      int guard;
      int q2_before;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = '0;
      out_ready = 4'b0000;
      for (int i = 0; i < 4; i++) pops[i] = 0;
      @(posedge clk);
      #1;
      do_reset();

      // Basic routing: each word one cycle later on its own output.
      step(1'b1, 2'd3, 64'hA3, 4'hF, a);
      step(1'b1, 2'd2, 64'hA2, 4'hF, a);
      step(1'b1, 2'd1, 64'hA1, 4'hF, a);
      step(1'b1, 2'd0, 64'hA0, 4'hF, a);
      idle(4'hF, 2);
      for (int i = 0; i < 4; i++) chk($sformatf("route_pops[%0d]", i), 64'(pops[i]), 64'd1);

      // Fill and backpressure on queue 1.
      step(1'b1, 2'd1, 64'h1, 4'h0, a);
      step(1'b1, 2'd1, 64'h2, 4'h0, a);
      in_valid = 1'b1; in_sel = 2'd1; in_data = 64'h3; out_ready = 4'h0;
      #1;
      chk("full_occ1", 64'(occupancy[CW +: CW]), 64'd2);
      chk("full_ready1", 64'(in_ready), 64'd0);
      in_sel = 2'd2;
      #1;
      chk("other_ready2", 64'(in_ready), 64'd1);
      in_sel = 2'd1;

      // Full with simultaneous push and pop.
      step(1'b1, 2'd1, 64'h3, 4'b0010, a);
      chk("full_pushpop_acc", 64'(a), 64'd1);
      chk("full_pushpop_occ", 64'(occupancy[CW +: CW]), 64'd2);
      idle(4'b0010, 3);
      chk("drain_occ1", 64'(occupancy[CW +: CW]), 64'd0);

      // Stall stability on queue 0.
      pops[0] = 0;
      step(1'b1, 2'd0, 64'hDEAD_BEEF, 4'h0, a);
      idle(4'h0, 5);
      idle(4'b0001, 1);
      idle(4'b0001, 2);
      chk("stall_pops0", 64'(pops[0]), 64'd1);

      // Wrap-around on queue 2 with toggling ready.
      q2_before = pops[2];
      for (int w = 0; w < 10; w++) begin
         guard = 0;
         a = 1'b0;
         while (!a && guard < 20) begin
            step(1'b1, 2'd2, 64'h10 + 64'(w), {1'b0, (($time / 10) % 2) == 0, 2'b00}, a);
            guard++;
         end
         if (!a) chk("wrap_accept_timeout", 64'd0, 64'd1);
      end
      idle(4'b0100, 3);
      chk("wrap_pops2", 64'(pops[2] - q2_before), 64'd10);

      // Reset mid-operation.
      step(1'b1, 2'd0, 64'hB0, 4'h0, a);
      step(1'b1, 2'd0, 64'hB1, 4'h0, a);
      step(1'b1, 2'd3, 64'hC0, 4'h0, a);
      step(1'b1, 2'd3, 64'hC1, 4'h0, a);
      chk("pre_rst_occ", 64'(occupancy), 64'(8'b10_00_00_10));
      do_reset();
      pops[3] = 0;
      step(1'b1, 2'd3, 64'h77, 4'hF, a);
      idle(4'hF, 3);
      chk("post_rst_pops3", 64'(pops[3]), 64'd1);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              {$urandom, $urandom}, 4'($urandom_range(0, 15)), a);
      end
      idle(4'hF, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("final_empty[%0d]", i), 64'(exp_q[i].size()), 64'd0);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_demux4_64_q
`default_nettype wire
